// File: rtl/frame_stream_gen.sv
// Raster frame-stream source for the pre_frame_* pixel interface: programmable timing,
// built-in test patterns, and clean stop on frame boundaries.
module frame_stream_gen #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_BLANK  = 160,
  parameter int         V_ACTIVE = 480,
  parameter int         V_BLANK  = 45,
  parameter logic [7:0] BOX_LVL  = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  pattern_sel,
  input  logic [7:0]  solid_y,
  output logic        post_frame_vsync,
  output logic        post_frame_hsync,
  output logic        post_frame_valid,
  output logic [7:0]  post_img_y,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] BOX_H_LO = HW'(H_ACTIVE / 4);
  localparam logic [HW-1:0] BOX_H_HI = HW'((3 * H_ACTIVE) / 4);
  localparam logic [VW-1:0] BOX_V_LO = VW'(V_ACTIVE / 4);
  localparam logic [VW-1:0] BOX_V_HI = VW'((3 * V_ACTIVE) / 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t          state_q;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [2:0]      pat_q;
  logic [7:0]      solid_q;

  logic            vsync_q;
  logic            hsync_q;
  logic [7:0]      y_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     cnt_q;

  logic            in_frame;
  logic            frame_end;
  logic            v_act;
  logic            h_act;
  logic            in_box;
  logic [7:0]      h8;
  logic [7:0]      v8;
  logic [7:0]      pix;

  assign in_frame  = (state_q != S_IDLE);
  assign frame_end = in_frame && (h_q == H_LAST) && (v_q == V_LAST);
  assign v_act     = (v_q < V_ACT);
  assign h_act     = (h_q < H_ACT);
  assign h8        = 8'(h_q);
  assign v8        = 8'(v_q);
  assign in_box    = (h_q >= BOX_H_LO) && (h_q < BOX_H_HI) &&
                     (v_q >= BOX_V_LO) && (v_q < BOX_V_HI);

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (in_frame) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  always_comb begin
    pix = 8'h00;
    case (pat_q)
      3'd0:    pix = h8;
      3'd1:    pix = v8;
      3'd2:    pix = (h8[3] ^ v8[3]) ? 8'hFF : 8'h00;
      3'd3:    pix = solid_q;
      3'd4:    pix = in_box ? BOX_LVL : 8'h00;
      default: pix = 8'h00;
    endcase
  end

  // Ports are registered from the current (state, h, v), giving one clock of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= '0;
      solid_q <= '0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vsync_q <= in_frame && v_act;
      hsync_q <= in_frame && v_act && h_act;
      y_q     <= (in_frame && v_act && h_act) ? pix : 8'h00;
      busy_q  <= in_frame;
      done_q  <= frame_end;
      if (frame_end) begin
        cnt_q <= cnt_q + 16'd1;
      end
      h_q <= h_d;
      v_q <= v_d;

      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_RUN;
            pat_q   <= pattern_sel;
            solid_q <= solid_y;
          end
        end
        S_RUN: begin
          if (frame_end) begin
            if (enable) begin
              pat_q   <= pattern_sel;
              solid_q <= solid_y;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (!enable) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (frame_end) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign post_frame_vsync = vsync_q;
  assign post_frame_hsync = hsync_q;
  assign post_frame_valid = hsync_q;
  assign post_img_y       = y_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign frame_cnt        = cnt_q;

endmodule

// File: tb/tb_frame_stream_gen.sv
// Bench for frame_stream_gen: every clock is compared against a frame-time reference model,
// plus directed checks on latency, drain behaviour, reset and inter-frame gap.
module tb_frame_stream_gen;

  localparam int HA = 16;
  localparam int HB = 4;
  localparam int VA = 8;
  localparam int VB = 2;
  localparam int HT = HA + HB;
  localparam int VT = VA + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  pattern_sel = 3'd0;
  logic [7:0]  solid_y = 8'd0;
  logic        post_frame_vsync;
  logic        post_frame_hsync;
  logic        post_frame_valid;
  logic [7:0]  post_img_y;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: a frame is a run of FT clocks indexed by m_t.
  bit          m_run = 1'b0;
  bit          m_stop = 1'b0;
  int          m_t = 0;
  int          m_pat = 0;
  logic [7:0]  m_solid = 8'd0;
  logic [15:0] m_cnt = 16'd0;
  int          done_seen = 0;

  always #5 clk = ~clk;

  frame_stream_gen #(
    .H_ACTIVE(HA),
    .H_BLANK (HB),
    .V_ACTIVE(VA),
    .V_BLANK (VB),
    .BOX_LVL (8'd255)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .pattern_sel     (pattern_sel),
    .solid_y         (solid_y),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_hsync(post_frame_hsync),
    .post_frame_valid(post_frame_valid),
    .post_img_y      (post_img_y),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_cnt       (frame_cnt)
  );

  function automatic logic [7:0] ref_pix(input int p, input int h, input int v, input logic [7:0] s);
    case (p)
      0: return 8'(h % 256);
      1: return 8'(v % 256);
      2: return (((h / 8) % 2) != ((v / 8) % 2)) ? 8'hFF : 8'h00;
      3: return s;
      4: return (h >= HA / 4 && h < 3 * HA / 4 && v >= VA / 4 && v < 3 * VA / 4) ? 8'd255 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    logic       e_vs;
    logic       e_hs;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_y;
    int         h;
    int         v;
    e_vs   = 1'b0;
    e_hs   = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_y    = 8'd0;
    if (m_run) begin
      h      = m_t % HT;
      v      = m_t / HT;
      e_busy = 1'b1;
      e_vs   = (v < VA);
      e_hs   = e_vs && (h < HA);
      e_y    = e_hs ? ref_pix(m_pat, h, v, m_solid) : 8'd0;
      e_done = (m_t == FT - 1);
      if (!enable) m_stop = 1'b1;
      if (e_done) begin
        m_cnt = m_cnt + 16'd1;
        if (m_stop) begin
          m_run = 1'b0;
        end else begin
          m_t     = 0;
          m_pat   = int'(pattern_sel);
          m_solid = solid_y;
        end
      end else begin
        m_t++;
      end
    end else if (enable) begin
      m_run   = 1'b1;
      m_stop  = 1'b0;
      m_t     = 0;
      m_pat   = int'(pattern_sel);
      m_solid = solid_y;
    end
    @(posedge clk);
    #1;
    chk("vsync", 32'(post_frame_vsync), 32'(e_vs));
    chk("hsync", 32'(post_frame_hsync), 32'(e_hs));
    chk("valid", 32'(post_frame_valid), 32'(e_hs));
    chk("img_y", 32'(post_img_y), 32'(e_y));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("hsync_without_vsync", 32'(post_frame_hsync & ~post_frame_vsync), 32'd0);
    if (frame_done) done_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {post_frame_vsync, post_frame_hsync, post_frame_valid, post_img_y,
              busy, frame_done, frame_cnt}, 32'd0);
  endtask

  // Enable is raised just after a clock edge; the first valid pixel must follow two edges later.
  task automatic first_pixel_latency(input string tag);
    int n;
    n = 0;
    enable = 1'b1;
    do begin
      step();
      n++;
    end while (!post_frame_valid && n < 10);
    chk(tag, 32'(n), 32'd2);
  endtask

  initial begin
    int n;

    // Reset state
    #2;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    run(3);

    // Ramp pattern, enable held through one full frame
    pattern_sel = 3'd0;
    first_pixel_latency("first_pixel_latency");
    run(FT);

    // Drop enable on line 1 of the second frame: that frame finishes, nothing follows
    run(HT);
    enable    = 1'b0;
    done_seen = 0;
    run(2 * FT);
    chk("drain_done_once", 32'(done_seen), 32'd1);
    chk("drain_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("drain_busy_low", 32'(busy), 32'd0);
    chk("drain_no_vsync", 32'(post_frame_vsync), 32'd0);

    // Pattern change mid-frame takes effect only on the next frame
    pattern_sel = 3'd0;
    enable      = 1'b1;
    run(HT * 3);
    pattern_sel = 3'd2;
    run(FT);
    enable = 1'b0;
    run(2 * FT);

    // Centred box
    pattern_sel = 3'd4;
    enable      = 1'b1;
    run(FT + 5);
    enable = 1'b0;
    run(2 * FT);

    // Asynchronous reset in the middle of line 2
    pattern_sel = 3'd3;
    solid_y     = 8'($urandom_range(1, 255));
    enable      = 1'b1;
    step();
    run(2 * HT + 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid_frame");
    m_run  = 1'b0;
    m_stop = 1'b0;
    m_cnt  = 16'd0;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(2);
    pattern_sel = 3'd1;
    first_pixel_latency("first_pixel_after_reset");
    run(FT / 2);

    // Back-to-back frames: the vsync gap is exactly the vertical blank
    n = 0;
    while (post_frame_vsync && n < FT) begin
      pattern_sel = 3'($urandom_range(0, 7));
      solid_y     = 8'($urandom);
      step();
      n++;
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!post_frame_vsync && n < 2 * FT);
    chk("vblank_gap", 32'(n), 32'(VB * HT));
    for (int i = 0; i < 3 * FT; i++) begin
      pattern_sel = 3'($urandom_range(0, 7));
      solid_y     = 8'($urandom);
      step();
    end

    // Randomised enable and pattern activity
    for (int i = 0; i < 6 * FT; i++) begin
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      pattern_sel = 3'($urandom_range(0, 7));
      solid_y     = 8'($urandom);
      step();
    end
    enable = 1'b0;
    run(2 * FT);
    chk("final_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
